// File: rtl/counter_checker.sv
// Checks an incoming count stream together with its mod-3 and mod-7 residues.
// It locks onto a consistent stream and then counts and classifies mismatches.
module counter_checker #(
    parameter int WIDTH  = 32,
    parameter int LOCK_N = 4,
    parameter int MISS_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] mod3_in,
    input  logic [WIDTH-1:0] mod7_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [15:0]      err_cnt,
    output logic [2:0]       err_type,
    output logic [WIDTH-1:0] exp_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int MCW = $clog2(LOCK_N + 1);
    localparam int XCW = $clog2(MISS_N + 1);
    localparam logic [MCW-1:0] LOCK_V = MCW'(LOCK_N);
    localparam logic [XCW-1:0] MISS_V = XCW'(MISS_N);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_cnt_q, exp_cnt_d;
    logic [1:0]       r3_q, r3_d;
    logic [2:0]       r7_q, r7_d;
    logic [MCW-1:0]   match_q, match_d;
    logic [XCW-1:0]   miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [2:0]       err_type_q, err_type_d;

    // Incremental residue tracking; a count wrap forces both residues to zero.
    logic [WIDTH-1:0] adv_cnt, seed_cnt;
    logic [1:0]       adv_r3, seed_r3;
    logic [2:0]       adv_r7, seed_r7;
    logic             cnt_bad, m3_bad, m7_bad, sample_ok, range_ok;

    always_comb begin
        adv_cnt  = exp_cnt_q + 1'b1;
        adv_r3   = (adv_cnt == '0 || r3_q == 2'd2) ? 2'd0 : r3_q + 2'd1;
        adv_r7   = (adv_cnt == '0 || r7_q == 3'd6) ? 3'd0 : r7_q + 3'd1;
        seed_cnt = cnt_in + 1'b1;
        seed_r3  = (seed_cnt == '0 || mod3_in[1:0] == 2'd2) ? 2'd0 : mod3_in[1:0] + 2'd1;
        seed_r7  = (seed_cnt == '0 || mod7_in[2:0] == 3'd6) ? 3'd0 : mod7_in[2:0] + 3'd1;

        cnt_bad   = (cnt_in != exp_cnt_q);
        m3_bad    = (mod3_in != WIDTH'(r3_q));
        m7_bad    = (mod7_in != WIDTH'(r7_q));
        sample_ok = !cnt_bad && !m3_bad && !m7_bad;
        range_ok  = (mod3_in < WIDTH'(3)) && (mod7_in < WIDTH'(7));
    end

    always_comb begin
        state_d     = state_q;
        exp_cnt_d   = exp_cnt_q;
        r3_d        = r3_q;
        r7_d        = r7_q;
        match_d     = match_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_type_d  = err_type_q;

        if (in_valid) begin
            if (state_q == HUNT || (state_q == VERIFY && !sample_ok)) begin
                // A mismatch during VERIFY is treated as a fresh HUNT sample.
                if (range_ok) begin
                    exp_cnt_d = seed_cnt;
                    r3_d      = seed_r3;
                    r7_d      = seed_r7;
                    match_d   = MCW'(1);
                    state_d   = (LOCK_N <= 1) ? LOCKED : VERIFY;
                    locked_d  = (LOCK_N <= 1);
                end else begin
                    match_d  = '0;
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
                miss_d = '0;
            end else if (state_q == VERIFY) begin
                exp_cnt_d = adv_cnt;
                r3_d      = adv_r3;
                r7_d      = adv_r7;
                match_d   = match_q + 1'b1;
                if (match_q + 1'b1 == LOCK_V) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end
            end else begin
                exp_cnt_d = adv_cnt;
                r3_d      = adv_r3;
                r7_d      = adv_r7;
                if (sample_ok) begin
                    miss_d = '0;
                end else begin
                    err_pulse_d = 1'b1;
                    err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                    err_type_d  = err_type_q | {m7_bad, m3_bad, cnt_bad};
                    miss_d      = miss_q + 1'b1;
                    if (miss_q + 1'b1 == MISS_V) begin
                        state_d  = HUNT;
                        locked_d = 1'b0;
                        miss_d   = '0;
                        match_d  = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            exp_cnt_q   <= '0;
            r3_q        <= '0;
            r7_q        <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            err_type_q  <= '0;
        end else begin
            state_q     <= state_d;
            exp_cnt_q   <= exp_cnt_d;
            r3_q        <= r3_d;
            r7_q        <= r7_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            err_type_q  <= err_type_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign err_type  = err_type_q;
    assign exp_cnt   = exp_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: lock, single error, loss of lock, relock,
// VERIFY/HUNT reseeding, gaps, mid-stream reset and 8-bit count wrap.
module tb_counter_checker;

    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] cnt = '0;
    logic [31:0] m3 = '0;
    logic [31:0] m7 = '0;

    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [2:0]  err_type;
    logic [31:0] exp_cnt;
    logic [1:0]  dbg_state;

    logic        locked8, err_pulse8;
    logic [15:0] err_cnt8;
    logic [2:0]  err_type8;
    logic [7:0]  exp_cnt8;
    logic [1:0]  dbg_state8;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(32), .LOCK_N(4), .MISS_N(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .cnt_in(cnt), .mod3_in(m3), .mod7_in(m7),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .err_type(err_type), .exp_cnt(exp_cnt), .dbg_state(dbg_state)
    );

    counter_checker #(.WIDTH(8), .LOCK_N(4), .MISS_N(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .cnt_in(cnt[7:0]), .mod3_in(m3[7:0]), .mod7_in(m7[7:0]),
        .locked(locked8), .err_pulse(err_pulse8), .err_cnt(err_cnt8),
        .err_type(err_type8), .exp_cnt(exp_cnt8), .dbg_state(dbg_state8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle at the falling edge, return 1 time unit after the rising edge.
    task automatic smp(input logic v, input logic [31:0] c, input logic [31:0] r3, input logic [31:0] r7);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = v;
        cnt = c;
        m3 = r3;
        m7 = r7;
        @(posedge clk);
        #1;
    endtask

    task automatic good(input logic [31:0] c);
        smp(1'b1, c, c % 3, c % 7);
    endtask

    task automatic do_rst(input logic [31:0] c);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        cnt = c;
        m3 = c % 3;
        m7 = c % 7;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_pulse"}, 64'(err_pulse), 64'd0);
        chk({tag, "_errcnt"}, 64'(err_cnt), 64'd0);
        chk({tag, "_errtype"}, 64'(err_type), 64'd0);
        chk({tag, "_expcnt"}, 64'(exp_cnt), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(S_HUNT));
    endtask

    initial begin
        // Reset with a valid sample present: it must be ignored.
        do_rst(32'd77);
        do_rst(32'd78);
        chk_reset("por");

        // HUNT with out-of-range residue stays put.
        smp(1'b1, 32'd5, 32'd0, 32'd7);
        chk("hunt_oor_state", 64'(dbg_state), 64'(S_HUNT));
        chk("hunt_oor_exp", 64'(exp_cnt), 64'd0);

        // Lock on 10..13.
        smp(1'b1, 32'd10, 32'd1, 32'd3);
        chk("seed_state", 64'(dbg_state), 64'(S_VERIFY));
        chk("seed_exp", 64'(exp_cnt), 64'd11);
        chk("seed_locked", 64'(locked), 64'd0);
        smp(1'b1, 32'd11, 32'd2, 32'd4);
        smp(1'b1, 32'd12, 32'd0, 32'd5);
        chk("pre_lock", 64'(locked), 64'd0);
        smp(1'b1, 32'd13, 32'd1, 32'd6);
        chk("lock_locked", 64'(locked), 64'd1);
        chk("lock_exp", 64'(exp_cnt), 64'd14);
        chk("lock_errcnt", 64'(err_cnt), 64'd0);

        // Idle cycle with garbage data holds everything.
        smp(1'b0, 32'hDEAD, 32'd9, 32'd9);
        chk("gap_exp", 64'(exp_cnt), 64'd14);
        chk("gap_pulse", 64'(err_pulse), 64'd0);
        chk("gap_locked", 64'(locked), 64'd1);

        // Valid stream with interleaved gaps up to expecting 20/2/6.
        for (int c = 14; c < 20; c++) begin
            if (c % 3 == 1) smp(1'b0, 32'd0, 32'd5, 32'd5);
            good(32'(c));
            chk("stream_pulse", 64'(err_pulse), 64'd0);
        end
        chk("stream_exp", 64'(exp_cnt), 64'd20);
        chk("stream_errcnt", 64'(err_cnt), 64'd0);

        // Single mod3 error.
        smp(1'b1, 32'd20, 32'd1, 32'd6);
        chk("err1_pulse", 64'(err_pulse), 64'd1);
        chk("err1_type", 64'(err_type), 64'b010);
        chk("err1_cnt", 64'(err_cnt), 64'd1);
        chk("err1_exp", 64'(exp_cnt), 64'd21);
        smp(1'b1, 32'd21, 32'd0, 32'd0);
        chk("ok21_pulse", 64'(err_pulse), 64'd0);
        chk("ok21_locked", 64'(locked), 64'd1);

        // Three consecutive bad samples lose lock.
        smp(1'b1, 32'd99, 32'd1, 32'd1);
        chk("bad1_pulse", 64'(err_pulse), 64'd1);
        chk("bad1_type", 64'(err_type), 64'b011);
        smp(1'b1, 32'd23, 32'd0, 32'd5);
        chk("bad2_locked", 64'(locked), 64'd1);
        chk("bad2_type", 64'(err_type), 64'b111);
        smp(1'b1, 32'd24, 32'd0, 32'd0);
        chk("bad3_pulse", 64'(err_pulse), 64'd1);
        chk("bad3_locked", 64'(locked), 64'd0);
        chk("bad3_errcnt", 64'(err_cnt), 64'd4);
        chk("bad3_state", 64'(dbg_state), 64'(S_HUNT));
        smp(1'b0, 32'd0, 32'd0, 32'd0);
        chk("post_loss_pulse", 64'(err_pulse), 64'd0);

        // Relock keeps the error history.
        for (int c = 100; c < 104; c++) begin
            good(32'(c));
            chk("relock_pulse", 64'(err_pulse), 64'd0);
        end
        chk("relock_locked", 64'(locked), 64'd1);
        chk("relock_errcnt", 64'(err_cnt), 64'd4);
        chk("relock_type", 64'(err_type), 64'b111);
        chk("relock_exp", 64'(exp_cnt), 64'd104);

        // One-cycle reset while locked.
        do_rst(32'd104);
        chk_reset("midrst");

        // VERIFY mismatch reseeds; VERIFY out-of-range returns to HUNT, no errors counted.
        good(32'd50);
        chk("v_seed_exp", 64'(exp_cnt), 64'd51);
        good(32'd70);
        chk("v_reseed_exp", 64'(exp_cnt), 64'd71);
        chk("v_reseed_state", 64'(dbg_state), 64'(S_VERIFY));
        chk("v_reseed_pulse", 64'(err_pulse), 64'd0);
        smp(1'b1, 32'd80, 32'd3, 32'd0);
        chk("v_oor_exp", 64'(exp_cnt), 64'd71);
        chk("v_oor_state", 64'(dbg_state), 64'(S_HUNT));
        chk("v_errcnt", 64'(err_cnt), 64'd0);

        // 8-bit wrap: after 255 the residues restart at zero.
        do_rst(32'd0);
        for (int c = 252; c < 256; c++) good(32'(c));
        chk("wrap_locked", 64'(locked8), 64'd1);
        chk("wrap_exp", 64'(exp_cnt8), 64'd0);
        smp(1'b1, 32'd0, 32'd0, 32'd0);
        chk("wrap0_pulse", 64'(err_pulse8), 64'd0);
        chk("wrap0_exp", 64'(exp_cnt8), 64'd1);
        smp(1'b1, 32'd1, 32'd1, 32'd1);
        chk("wrap1_pulse", 64'(err_pulse8), 64'd0);
        chk("wrap1_errcnt", 64'(err_cnt8), 64'd0);
        chk("wrap1_locked", 64'(locked8), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter WIDTH, default 32: width of the count and residue inputs; legal range 8..64.
REQ-002 Parameter LOCK_N, default 4: consecutive consistent samples required to declare lock.
REQ-003 Parameter MISS_N, default 3: consecutive mismatches while locked that force loss of lock.
REQ-004 Port clk  input  1: the only clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n  input  1: reset, synchronous and active-low.
REQ-006 Port in_valid  input  1: qualifies the three data inputs this cycle.
REQ-007 Port cnt_in  input  WIDTH: received count value.
REQ-008 Port mod3_in  input  WIDTH: received count modulo 3.
REQ-009 Port mod7_in  input  WIDTH: received count modulo 7.
REQ-010 Port locked  output  1: high while in LOCKED state.
REQ-011 Port err_pulse  output  1: one-cycle pulse per mismatching sample while LOCKED.
REQ-012 Port err_cnt  output  16: saturating count of err_pulse events.
REQ-013 Port err_type  output  3: sticky flags {mod7 bad, mod3 bad, count bad}.
REQ-014 Port exp_cnt  output  WIDTH: count value expected on the next valid sample.

Function
REQ-015 The block SHALL contain no divider; expected residues are tracked incrementally: r3 in 0..2 and r7 in 0..6.
REQ-016 Each valid sample SHALL advance the expected values: exp_cnt+1 modulo 2^WIDTH, r3+1 wrapping 2->0, r7+1 wrapping 6->0.
REQ-017 When exp_cnt wraps from all-ones to 0, r3 and r7 SHALL both load 0, regardless of their incremented values.
REQ-018 A sample matches when cnt_in==exp_cnt, mod3_in==r3 and mod7_in==r7.
REQ-019 The FSM SHALL have three states: HUNT, VERIFY and LOCKED; the reset state is HUNT.
REQ-020 HUNT, valid sample with mod3_in<3 and mod7_in<7: seed the expected values from the sample, advanced per REQ-016/017; set match count to 1; go to VERIFY.
REQ-021 HUNT, valid sample with an out-of-range residue: the block SHALL stay in HUNT and leave the expected values unchanged.
REQ-022 VERIFY, matching sample: increment match count and advance the expected values; when the count reaches LOCK_N, go to LOCKED on that same edge.
REQ-023 VERIFY, mismatching sample: the block SHALL behave exactly as HUNT would for that sample (reseed or stay).
REQ-024 LOCKED, matching sample: advance the expected values and clear the miss count.
REQ-025 LOCKED, mismatching sample, all of the following SHALL happen on the same edge:
- err_pulse high the next cycle;
- err_cnt increments, saturating at 16'hFFFF;
- err_type ORs in the failing fields;
- the miss count increments;
- the expected values still advance.
REQ-026 LOCKED, MISS_N consecutive mismatches: go to HUNT after the error of the MISS_N-th sample is recorded; err_cnt and err_type SHALL be kept.
REQ-027 in_valid low: state, counters and expected values SHALL hold, and err_pulse SHALL be 0.
REQ-028 Every output SHALL be registered; a sample presented at edge N SHALL be reflected in the outputs after edge N (latency 1).
REQ-029 err_pulse SHALL fire only in LOCKED; mismatches in HUNT and VERIFY SHALL NOT count as errors.

Reset
REQ-030 When rst_n is low at a rising edge, the block SHALL reset on that edge; a mid-stream reset SHALL abandon any lock, match count or miss count.
REQ-031 Reset values: state HUNT, locked 0, err_pulse 0, err_cnt 0, err_type 0, exp_cnt 0, r3 0, r7 0, match count 0, miss count 0.
REQ-032 A sample presented in a cycle where rst_n is low SHALL be ignored.

Verification
REQ-033 Lock: LOCK_N=4, feed valid 10/1/3, 11/2/4, 12/0/5, 13/1/6 -> locked=1 after the 4th sample, exp_cnt=14, err_cnt=0.
REQ-034 Single error: while locked expecting 20/2/6, inject 20/1/6 -> one err_pulse, err_type=3'b010, err_cnt=1; next 21/0/0 -> no pulse, still locked.
REQ-035 Loss of lock: MISS_N=3, three consecutive bad samples -> err_cnt=3 and locked=0 after the third; a valid stream then relocks after 4 samples with err_cnt still 3.
REQ-036 Wrap: WIDTH=8, lock on 252..255 with correct residues -> exp_cnt=0, r3=0, r7=0; sample 0/0/0 -> no error.
REQ-037 Gaps and reset: random in_valid gaps during a valid stream -> no errors; rst_n low for 1 cycle while locked -> all outputs at reset values next cycle.
